// File: rtl/riscv_soft_mul_div_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operation encodings and the log2 helper used to size the step counter.
package riscv_soft_mul_div_pkg;

   typedef enum logic [2:0] {
      MD_OP_MUL    = 3'd0,
      MD_OP_MULH   = 3'd1,
      MD_OP_MULHSU = 3'd2,
      MD_OP_MULHU  = 3'd3,
      MD_OP_DIV    = 3'd4,
      MD_OP_DIVU   = 3'd5,
      MD_OP_REM    = 3'd6,
      MD_OP_REMU   = 3'd7
   } md_op_e;

   // Smallest r with 2**r >= value.
   function automatic int md_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/riscv_soft_mul_div.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes,
// sign correction and special cases resolved when the result is registered.
module riscv_soft_mul_div
   import riscv_soft_mul_div_pkg::*;
#(
   parameter int XPR_LEN = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_op,
   input  logic [XPR_LEN-1:0] req_in_1,
   input  logic [XPR_LEN-1:0] req_in_2,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [XPR_LEN-1:0] resp_result
);

   localparam int                 CNT_W    = md_log2(XPR_LEN);
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(XPR_LEN - 1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [XPR_LEN-1:0] X_ZERO   = {XPR_LEN{1'b0}};
   localparam logic [XPR_LEN-1:0] X_ONES   = {XPR_LEN{1'b1}};
   localparam logic [XPR_LEN-1:0] X_ONE    = {{(XPR_LEN-1){1'b0}}, 1'b1};
   localparam logic [XPR_LEN-1:0] X_MIN    = {1'b1, {(XPR_LEN-1){1'b0}}};
   localparam logic [2*XPR_LEN-1:0] P_ZERO = {(2*XPR_LEN){1'b0}};
   localparam logic [2*XPR_LEN-1:0] P_ONE  = {{(2*XPR_LEN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      MD_STATE_IDLE    = 2'd0,
      MD_STATE_COMPUTE = 2'd1,
      MD_STATE_DONE    = 2'd2
   } md_state_e;

   md_state_e              state_r, state_s;
   md_op_e                 op_r, op_in_s;
   logic [2*XPR_LEN-1:0]   acc_r, acc_next_s, acc_load_s, prod_s;
   logic [XPR_LEN-1:0]     opnd_r, opnd_load_s;
   logic [XPR_LEN-1:0]     mag1_s, mag2_s, quot_s, rem_s, result_s, result_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   neg_r, div_zero_r, ovf_r;
   logic                   sgn_op1_s, sgn_op2_s, sign1_s, sign2_s;
   logic                   neg_s, div_zero_s, ovf_s;
   logic [XPR_LEN:0]       add_x_s, add_y_s;
   logic                   add_cin_s, no_borrow_s;
   logic [XPR_LEN+1:0]     sum_s;

   assign op_in_s     = md_op_e'(req_op);
   assign req_ready   = (state_r == MD_STATE_IDLE);
   assign resp_valid  = (state_r == MD_STATE_DONE);
   assign resp_result = result_r;

   // Request decode: operand signedness, magnitudes, negate and special-case flags.
   always_comb begin
      sgn_op1_s = 1'b0;
      sgn_op2_s = 1'b0;
      case (op_in_s)
         MD_OP_MULH, MD_OP_DIV, MD_OP_REM: begin
            sgn_op1_s = 1'b1;
            sgn_op2_s = 1'b1;
         end
         MD_OP_MULHSU: sgn_op1_s = 1'b1;
         default: ;
      endcase
      sign1_s = sgn_op1_s & req_in_1[XPR_LEN-1];
      sign2_s = sgn_op2_s & req_in_2[XPR_LEN-1];
      if (sign1_s) mag1_s = ~req_in_1 + X_ONE;
      else         mag1_s = req_in_1;
      if (sign2_s) mag2_s = ~req_in_2 + X_ONE;
      else         mag2_s = req_in_2;
      case (op_in_s)
         MD_OP_MULH, MD_OP_DIV:   neg_s = sign1_s ^ sign2_s;
         MD_OP_MULHSU, MD_OP_REM: neg_s = sign1_s;
         default:                 neg_s = 1'b0;
      endcase
      div_zero_s = (req_in_2 == X_ZERO);
      ovf_s      = ((op_in_s == MD_OP_DIV) || (op_in_s == MD_OP_REM)) &&
                   (req_in_1 == X_MIN) && (req_in_2 == X_ONES);
      // Multiplier (or dividend) rides in the low half and shifts out as bits are consumed.
      if (req_op[2]) begin
         acc_load_s  = {X_ZERO, mag1_s};
         opnd_load_s = mag2_s;
      end else begin
         acc_load_s  = {X_ZERO, mag2_s};
         opnd_load_s = mag1_s;
      end
   end

   // One iteration through the shared adder: shift-add for multiply, trial subtract for divide.
   always_comb begin
      if (op_r[2]) begin
         add_x_s   = {acc_r[2*XPR_LEN-1:XPR_LEN], acc_r[XPR_LEN-1]};
         add_y_s   = ~{1'b0, opnd_r};
         add_cin_s = 1'b1;
      end else begin
         add_x_s   = {1'b0, acc_r[2*XPR_LEN-1:XPR_LEN]};
         add_y_s   = acc_r[0] ? {1'b0, opnd_r} : {1'b0, X_ZERO};
         add_cin_s = 1'b0;
      end
      sum_s       = {1'b0, add_x_s} + {1'b0, add_y_s} + {{(XPR_LEN+1){1'b0}}, add_cin_s};
      no_borrow_s = sum_s[XPR_LEN+1];
      if (op_r[2]) begin
         if (no_borrow_s) acc_next_s = {sum_s[XPR_LEN-1:0], acc_r[XPR_LEN-2:0], 1'b1};
         else             acc_next_s = {add_x_s[XPR_LEN-1:0], acc_r[XPR_LEN-2:0], 1'b0};
      end else begin
         acc_next_s = {sum_s[XPR_LEN:0], acc_r[XPR_LEN-1:1]};
      end
   end

   // Final sign correction and special-case override, sampled on the last iteration.
   always_comb begin
      if (neg_r) prod_s = ~acc_next_s + P_ONE;
      else       prod_s = acc_next_s;
      if (neg_r) quot_s = ~acc_next_s[XPR_LEN-1:0] + X_ONE;
      else       quot_s = acc_next_s[XPR_LEN-1:0];
      // A zero divisor leaves the dividend in the remainder, so REM by zero needs no override.
      if (neg_r) rem_s = ~acc_next_s[2*XPR_LEN-1:XPR_LEN] + X_ONE;
      else       rem_s = acc_next_s[2*XPR_LEN-1:XPR_LEN];
      case (op_r)
         MD_OP_MUL:                             result_s = acc_next_s[XPR_LEN-1:0];
         MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: result_s = prod_s[2*XPR_LEN-1:XPR_LEN];
         MD_OP_DIV, MD_OP_DIVU: begin
            if (div_zero_r)  result_s = X_ONES;
            else if (ovf_r)  result_s = X_MIN;
            else             result_s = quot_s;
         end
         MD_OP_REM, MD_OP_REMU: begin
            if (ovf_r) result_s = X_ZERO;
            else       result_s = rem_s;
         end
         default: result_s = X_ZERO;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         MD_STATE_IDLE: begin
            if (req_valid) state_s = MD_STATE_COMPUTE;
            else           state_s = MD_STATE_IDLE;
         end
         MD_STATE_COMPUTE: begin
            if (cnt_r == CNT_ZERO) state_s = MD_STATE_DONE;
            else                   state_s = MD_STATE_COMPUTE;
         end
         MD_STATE_DONE: begin
            if (resp_ready) state_s = MD_STATE_IDLE;
            else            state_s = MD_STATE_DONE;
         end
         default: state_s = MD_STATE_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= MD_STATE_IDLE;
      else       state_r <= state_s;
   end

   // Datapath registers: operand latch on accept, iterate in COMPUTE, capture result at the end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r       <= MD_OP_MUL;
         acc_r      <= P_ZERO;
         opnd_r     <= X_ZERO;
         cnt_r      <= CNT_ZERO;
         neg_r      <= 1'b0;
         div_zero_r <= 1'b0;
         ovf_r      <= 1'b0;
         result_r   <= X_ZERO;
      end else begin
         case (state_r)
            MD_STATE_IDLE: begin
               if (req_valid) begin
                  op_r       <= op_in_s;
                  acc_r      <= acc_load_s;
                  opnd_r     <= opnd_load_s;
                  cnt_r      <= CNT_LOAD;
                  neg_r      <= neg_s;
                  div_zero_r <= div_zero_s;
                  ovf_r      <= ovf_s;
               end
            end
            MD_STATE_COMPUTE: begin
               acc_r <= acc_next_s;
               if (cnt_r == CNT_ZERO) result_r <= result_s;
               else                   cnt_r    <= cnt_r - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule
